// File: rtl/spi_cmd_decoder.sv
// Byte-level SPI command decoder with a 4-entry register file.
// It answers one byte per received byte and drives the LEDs through a blink engine.
module spi_cmd_decoder #(
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [7:0]  ID_BYTE    = 8'hB1
) (
  input  logic       i_clk,
  input  logic       i_sys_rst,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_rdy,
  input  logic       i_cs,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_rdy,
  output logic [4:0] o_led,
  output logic       o_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    R_ADDR = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_ID    = 8'h9F;

  state_t                state_r, state_s;
  logic [7:0]            addr_r, addr_s;
  logic [3:0][7:0]       regs_r, regs_s;
  logic [7:0]            tx_byte_s;
  logic                  tx_rdy_s;
  logic                  err_s;
  logic                  reg2_wr_s;
  logic                  cs_meta_r, cs_sync_r, cs_prev_r;
  logic                  cs_rise_s;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  tick_s;
  logic [7:0]            period_r;
  logic                  phase_r;

  // Chip select idles high, so the synchronizer resets high to avoid a false frame end.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      cs_meta_r <= 1'b1;
      cs_sync_r <= 1'b1;
      cs_prev_r <= 1'b1;
    end else begin
      cs_meta_r <= i_cs;
      cs_sync_r <= cs_meta_r;
      cs_prev_r <= cs_sync_r;
    end
  end

  assign cs_rise_s = cs_sync_r & ~cs_prev_r;

  // Frame parser: next state, register writes and the response for the current byte.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    regs_s    = regs_r;
    tx_byte_s = o_tx_byte;
    tx_rdy_s  = 1'b0;
    err_s     = 1'b0;
    reg2_wr_s = 1'b0;
    if (cs_rise_s) begin
      state_s = IDLE;
    end else if (i_rx_rdy) begin
      tx_rdy_s  = 1'b1;
      tx_byte_s = 8'h00;
      case (state_r)
        IDLE: begin
          case (i_rx_byte)
            CMD_WRITE: state_s = W_ADDR;
            CMD_READ:  state_s = R_ADDR;
            CMD_ID: begin
              state_s   = DRAIN;
              tx_byte_s = ID_BYTE;
            end
            default: begin
              state_s = DRAIN;
              err_s   = 1'b1;
            end
          endcase
        end
        W_ADDR: begin
          addr_s  = i_rx_byte;
          state_s = W_DATA;
        end
        W_DATA: begin
          if (addr_r <= 8'd3) begin
            regs_s[addr_r[1:0]] = i_rx_byte;
            reg2_wr_s           = (addr_r[1:0] == 2'd2);
          end else begin
            err_s = 1'b1;
          end
          state_s = DRAIN;
        end
        R_ADDR: begin
          if (i_rx_byte <= 8'd3) begin
            tx_byte_s = regs_r[i_rx_byte[1:0]];
          end else begin
            err_s = 1'b1;
          end
          state_s = DRAIN;
        end
        DRAIN:   state_s = DRAIN;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Parser state, register file and the SPI-facing response registers.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_r   <= IDLE;
      addr_r    <= 8'h00;
      regs_r    <= {4{8'h00}};
      o_tx_byte <= 8'h00;
      o_tx_rdy  <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      regs_r    <= regs_s;
      o_tx_byte <= tx_byte_s;
      o_tx_rdy  <= tx_rdy_s;
      o_err     <= err_s;
    end
  end

  assign tick_s = &prescale_r;

  // Blink engine; a period of zero parks the phase high so blinking LEDs stay lit.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      prescale_r <= {PRESCALE_W{1'b0}};
      period_r   <= 8'h00;
      phase_r    <= 1'b1;
    end else begin
      prescale_r <= prescale_r + PRESCALE_W'(1);
      if (reg2_wr_s || (regs_r[2] == 8'h00)) begin
        period_r <= 8'h00;
        phase_r  <= 1'b1;
      end else if (tick_s) begin
        if (period_r == (regs_r[2] - 8'd1)) begin
          period_r <= 8'h00;
          phase_r  <= ~phase_r;
        end else begin
          period_r <= period_r + 8'd1;
        end
      end else begin
        period_r <= period_r;
      end
    end
  end

  // LED drive: enabled LEDs follow the phase where the blink mask is set.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      o_led <= 5'h00;
    end else begin
      o_led <= regs_r[0][4:0] & (~regs_r[1][4:0] | {5{phase_r}});
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder (blink prescaler shortened to 4 bits).
module tb_spi_cmd_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic       cs;
  logic [7:0] tx_byte;
  logic       tx_rdy;
  logic [4:0] led;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  spi_cmd_decoder #(.PRESCALE_W(4), .ID_BYTE(8'hB1)) dut (
    .i_clk     (clk),
    .i_sys_rst (rst_n),
    .i_rx_byte (rx_byte),
    .i_rx_rdy  (rx_rdy),
    .i_cs      (cs),
    .o_tx_byte (tx_byte),
    .o_tx_rdy  (tx_rdy),
    .o_led     (led),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One byte strobe; reports tx_rdy just before the edge and the outputs just after it.
  task automatic send_byte(input logic [7:0] b, output logic pre, output logic rdy,
                           output logic [7:0] txb, output logic er);
    @(negedge clk);
    rx_byte = b;
    rx_rdy  = 1'b1;
    #1 pre = tx_rdy;
    @(posedge clk);
    #1;
    rdy = tx_rdy;
    txb = tx_byte;
    er  = err;
    @(negedge clk);
    rx_rdy  = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    logic p, r, e;
    logic [7:0] t;
    frame_start();
    send_byte(8'h01, p, r, t, e);
    send_byte(a, p, r, t, e);
    send_byte(d, p, r, t, e);
    frame_end();
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d, output logic er);
    logic p, r, e;
    logic [7:0] t;
    frame_start();
    send_byte(8'h02, p, r, t, e);
    send_byte(a, p, r, d, er);
    send_byte(8'h00, p, r, t, e);
    frame_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs = 1'b1;
    rx_rdy = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_byte, tx_rdy, led, err} !== 15'h0000)
      $display("FAIL reset_outputs: got tx=%h rdy=%b led=%h err=%b expected all zero", tx_byte, tx_rdy, led, err);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (led !== 5'h00) $display("FAIL reset_led_idle: got %h expected 00", led);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic p, r, e;
    logic [7:0] t;
    frame_start();
    send_byte(8'h01, p, r, t, e);
    send_byte(8'h00, p, r, t, e);
    send_byte(8'h1F, p, r, t, e);
    n_checks++;
    if (p !== 1'b0 || r !== 1'b1) $display("FAIL wr_latency: got pre=%b post=%b expected 0/1", p, r);
    else n_pass++;
    n_checks++;
    if (led !== 5'h00) $display("FAIL wr_led_not_yet: got %h expected 00", led);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (led !== 5'h1F) $display("FAIL wr_led_visible: got %h expected 1f", led);
    else n_pass++;
    n_checks++;
    if (tx_rdy !== 1'b0) $display("FAIL tx_rdy_single: got %b expected 0", tx_rdy);
    else n_pass++;
    frame_end();
    frame_start();
    send_byte(8'h02, p, r, t, e);
    send_byte(8'h00, p, r, t, e);
    n_checks++;
    if (t !== 8'h1F || r !== 1'b1 || e !== 1'b0)
      $display("FAIL rd_reg0: got tx=%h rdy=%b err=%b expected 1f/1/0", t, r, e);
    else n_pass++;
    send_byte(8'h00, p, r, t, e);
    frame_end();
  endtask

  task automatic test_id();
    logic p, r, e;
    logic [7:0] t;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hB1;
    exp_b[1] = 8'h00;
    exp_b[2] = 8'h00;
    frame_start();
    for (int i = 0; i < 3; i++) begin
      send_byte((i == 0) ? 8'h9F : 8'h00, p, r, t, e);
      n_checks++;
      if (t !== exp_b[i] || r !== 1'b1 || e !== 1'b0)
        $display("FAIL id_byte%0d: got tx=%h rdy=%b err=%b expected %h/1/0", i, t, r, e, exp_b[i]);
      else n_pass++;
    end
    frame_end();
  endtask

  task automatic test_errors();
    logic p, r, e;
    logic [7:0] t;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'h1F;
    exp_r[1] = 8'h00;
    exp_r[2] = 8'h00;
    exp_r[3] = 8'h00;
    frame_start();
    send_byte(8'h55, p, r, t, e);
    n_checks++;
    if (e !== 1'b1 || t !== 8'h00) $display("FAIL bad_cmd: got err=%b tx=%h expected 1/00", e, t);
    else n_pass++;
    send_byte(8'h9F, p, r, t, e);
    n_checks++;
    if (t !== 8'h00 || e !== 1'b0) $display("FAIL bad_cmd_drain: got tx=%h err=%b expected 00/0", t, e);
    else n_pass++;
    frame_end();
    frame_start();
    send_byte(8'h01, p, r, t, e);
    send_byte(8'h07, p, r, t, e);
    send_byte(8'hAA, p, r, t, e);
    n_checks++;
    if (e !== 1'b1) $display("FAIL bad_waddr: got err=%b expected 1", e);
    else n_pass++;
    frame_end();
    for (int i = 0; i < 4; i++) begin
      read_reg(8'(i), t, e);
      n_checks++;
      if (t !== exp_r[i] || e !== 1'b0)
        $display("FAIL regs_unchanged%0d: got %h err=%b expected %h/0", i, t, e, exp_r[i]);
      else n_pass++;
    end
    read_reg(8'h09, t, e);
    n_checks++;
    if (t !== 8'h00 || e !== 1'b1) $display("FAIL bad_raddr: got tx=%h err=%b expected 00/1", t, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    write_reg(8'h03, 8'h5A);
    frame_start();
    @(negedge clk);
    rx_byte = 8'h02;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_rdy !== 1'b1 || tx_byte !== 8'h00) $display("FAIL b2b_first: got rdy=%b tx=%h expected 1/00", tx_rdy, tx_byte);
    else n_pass++;
    @(negedge clk);
    rx_byte = 8'h03;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_rdy !== 1'b1 || tx_byte !== 8'h5A) $display("FAIL b2b_second: got rdy=%b tx=%h expected 1/5a", tx_rdy, tx_byte);
    else n_pass++;
    @(negedge clk);
    rx_rdy = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_rdy !== 1'b0 || tx_byte !== 8'h5A) $display("FAIL b2b_hold: got rdy=%b tx=%h expected 0/5a", tx_rdy, tx_byte);
    else n_pass++;
    frame_end();
  endtask

  task automatic test_blink();
    logic prev;
    logic found;
    int c;
    int bad;
    write_reg(8'h01, 8'h03);
    write_reg(8'h02, 8'h02);
    bad = 0;
    prev = led[0];
    found = 1'b0;
    c = 0;
    while (!found && c < 80) begin
      @(negedge clk);
      c++;
      if (led[0] !== prev) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL blink_start: no toggle within %0d clocks, expected one within 80", c);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      prev = led[0];
      found = 1'b0;
      c = 0;
      while (!found && c < 80) begin
        @(negedge clk);
        c++;
        if (led[4:2] !== 3'b111 || led[1] !== led[0]) bad++;
        if (led[0] !== prev) found = 1'b1;
      end
      n_checks++;
      if (c !== 32) $display("FAIL blink_period%0d: got %0d clocks expected 32", k, c);
      else n_pass++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL blink_static: got %0d bad samples expected 0", bad);
    else n_pass++;
    write_reg(8'h02, 8'h00);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (led !== 5'h1F) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL blink_off_steady: got %0d samples not 1f expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic p, r, e;
    logic [7:0] t;
    frame_start();
    send_byte(8'h01, p, r, t, e);
    send_byte(8'h02, p, r, t, e);
    frame_end();
    frame_start();
    send_byte(8'h02, p, r, t, e);
    n_checks++;
    if (e !== 1'b0 || t !== 8'h00) $display("FAIL abort_cmd: got err=%b tx=%h expected 0/00", e, t);
    else n_pass++;
    send_byte(8'h02, p, r, t, e);
    n_checks++;
    if (t !== 8'h00) $display("FAIL abort_read: got %h expected 00", t);
    else n_pass++;
    frame_end();
    read_reg(8'h02, t, e);
    n_checks++;
    if (t !== 8'h00) $display("FAIL abort_reg2: got %h expected 00", t);
    else n_pass++;
    frame_start();
    @(negedge clk);
    cs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rx_byte = 8'h9F;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_rdy !== 1'b0) $display("FAIL cs_coincident: got tx_rdy=%b expected 0", tx_rdy);
    else n_pass++;
    @(negedge clk);
    rx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    frame_start();
    send_byte(8'h9F, p, r, t, e);
    n_checks++;
    if (t !== 8'hB1 || r !== 1'b1) $display("FAIL after_cs_abort: got tx=%h rdy=%b expected b1/1", t, r);
    else n_pass++;
    frame_end();
  endtask

  task automatic test_reset_mid_frame();
    logic p, r, e;
    logic [7:0] t;
    frame_start();
    send_byte(8'h02, p, r, t, e);
    send_byte(8'h00, p, r, t, e);
    n_checks++;
    if (led !== 5'h1F || t !== 8'h1F) $display("FAIL pre_reset: got led=%h tx=%h expected 1f/1f", led, t);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 5'h00 || tx_byte !== 8'h00) $display("FAIL reset_async: got led=%h tx=%h expected 00/00", led, tx_byte);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h9F, p, r, t, e);
    n_checks++;
    if (t !== 8'hB1 || e !== 1'b0) $display("FAIL post_reset_id: got tx=%h err=%b expected b1/0", t, e);
    else n_pass++;
    frame_end();
    read_reg(8'h00, t, e);
    n_checks++;
    if (t !== 8'h00) $display("FAIL post_reset_reg0: got %h expected 00", t);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id();
    test_errors();
    test_back_to_back();
    test_blink();
    test_abort();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
